// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// Optional madd (md_op=7) support is compiled in when MDU_MADD_EN is defined.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hl_sel,
   output logic [31:0] hl_out,
   output logic        busy
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'd7;
`endif

   logic [3:0]         cnt;
   logic [2:0]         op_p0;
   logic [31:0]        a_p0;
   logic [31:0]        b_p0;
   logic [31:0]        hi;
   logic [31:0]        lo;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [63:0]        res;

   // Returns {remainder, quotient}. Signed mode truncates toward zero and the
   // remainder follows the dividend; 0x8000_0000 / -1 falls out naturally as
   // quotient 0x8000_0000, remainder 0. Divide by zero yields {x, all-ones}.
   function automatic logic [63:0] div_res(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic        sgn);
      logic        x_neg;
      logic        y_neg;
      logic [31:0] x_mag;
      logic [31:0] y_mag;
      logic [31:0] q_mag;
      logic [31:0] r_mag;
      logic [31:0] q;
      logic [31:0] r;
      x_neg = sgn & x[31];
      y_neg = sgn & y[31];
      x_mag = x_neg ? (~x + 32'd1) : x;
      y_mag = y_neg ? (~y + 32'd1) : y;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else begin
         q_mag = x_mag / y_mag;
         r_mag = x_mag % y_mag;
         q = (x_neg ^ y_neg) ? (~q_mag + 32'd1) : q_mag;
         r = x_neg ? (~r_mag + 32'd1) : r_mag;
      end
      return {r, q};
   endfunction

   always_comb begin
      prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
      prod_u = {32'd0, a_p0} * {32'd0, b_p0};
      res    = {hi, lo};
      case (op_p0)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = div_res(a_p0, b_p0, 1'b1);
         OP_DIVU:  res = div_res(a_p0, b_p0, 1'b0);
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi, lo} + prod_s;
`endif
         default:  res = {hi, lo};
      endcase
   end

   // Acceptance is gated by busy, so completion and a new start never collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 4'd0;
         op_p0 <= 3'd0;
         a_p0  <= 32'd0;
         b_p0  <= 32'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            hi <= res[63:32];
            lo <= res[31:0];
         end
      end else if (start) begin
         case (md_op)
            OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
            , OP_MADD
`endif
            : begin
               cnt   <= 4'(MULT_CYCLES);
               op_p0 <= md_op;
               a_p0  <= a;
               b_p0  <= b;
            end
            OP_DIV, OP_DIVU: begin
               cnt   <= 4'(DIV_CYCLES);
               op_p0 <= md_op;
               a_p0  <= a;
               b_p0  <= b;
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

   assign busy   = (cnt != 4'd0);
   assign hl_out = hl_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo; define MDU_MADD_EN to cover madd.
module tb_mdu_hilo;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hl_sel;
   logic [31:0] hl_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .md_op  (md_op),
      .a      (a),
      .b      (b),
      .hl_sel (hl_sel),
      .hl_out (hl_out),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      hl_sel = 1'b1;
      #1 chk({tag, ".hi"}, hl_out, exp_hi);
      hl_sel = 1'b0;
      #1 chk({tag, ".lo"}, hl_out, exp_lo);
   endtask

   // Ends on the negedge of the first cycle after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start = 1'b1; md_op = op; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0; a = 32'hA5A5_5A5A; b = 32'h0F0F_0F0F;
   endtask

   task automatic run_busy(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, ".busy_hi"}, {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      chk({tag, ".busy_lo"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0; hl_sel = 1'b0;
      #2;
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk_hilo("reset", 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // mthi then mtlo back to back
      @(negedge clk);
      start = 1'b1; md_op = 3'd5; a = 32'h1234;
      @(negedge clk);
      chk("mthi.busy", {31'd0, busy}, 32'd0);
      hl_sel = 1'b1;
      #1 chk("mthi.next", hl_out, 32'h1234);
      md_op = 3'd6; a = 32'h5678;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      chk("mtlo.busy", {31'd0, busy}, 32'd0);
      chk_hilo("mtmove", 32'h1234, 32'h5678);

      // reset aborts a mult in flight
      issue(3'd1, 32'd3, 32'd4);
      chk("rstmid.busy_T1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rstmid.busy", {31'd0, busy}, 32'd0);
      chk_hilo("rstmid.during", 32'd0, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (7) @(negedge clk);
      chk("rstmid.after_busy", {31'd0, busy}, 32'd0);
      chk_hilo("rstmid.after", 32'd0, 32'd0);

      // signed and unsigned multiply
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      run_busy("mult", 5);
      chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      issue(3'd2, 32'hFFFF_FFFE, 32'd3);
      run_busy("multu", 5);
      chk_hilo("multu", 32'd2, 32'hFFFF_FFFA);

      // signed divide, HI/LO hold the previous value while busy
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      chk_hilo("div.hold", 32'd2, 32'hFFFF_FFFA);
      run_busy("div", 10);
      chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      issue(3'd4, 32'd7, 32'd0);
      run_busy("divu0", 10);
      chk_hilo("divu0", 32'd7, 32'hFFFF_FFFF);

      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_busy("divovf", 10);
      chk_hilo("divovf", 32'd0, 32'h8000_0000);

      issue(3'd4, 32'd100, 32'd7);
      run_busy("divu", 10);
      chk_hilo("divu", 32'd2, 32'd14);

      // start raised during busy is ignored
      issue(3'd1, 32'd2, 32'd3);
      chk("ign.busy_T1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("ign.busy_T2", {31'd0, busy}, 32'd1);
      start = 1'b1; md_op = 3'd3; a = 32'd9; b = 32'd3;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      run_busy("ign", 3);
      chk_hilo("ign", 32'd0, 32'd6);
      @(negedge clk);
      chk("ign.stay_idle", {31'd0, busy}, 32'd0);

      // md_op=0 with start does nothing
      issue(3'd0, 32'hDEAD_BEEF, 32'd1);
      chk("nop.busy", {31'd0, busy}, 32'd0);
      chk_hilo("nop", 32'd0, 32'd6);

      // madd accumulates (or is a no-op when not built in)
      issue(3'd5, 32'd0, 32'd0);
      issue(3'd6, 32'd10, 32'd0);
      issue(3'd7, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
      run_busy("madd", 5);
      chk_hilo("madd", 32'd0, 32'd16);
`else
      chk("madd_off.busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("madd_off.busy2", {31'd0, busy}, 32'd0);
      chk_hilo("madd_off", 32'd0, 32'd10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
